// File: rtl/aiv_video_timing_out.sv
// Pixel-slot video timing generator with a framebuffer request/flag interface and a
// registered RGB111 output stage aligned to the second clock of each pixel slot.
module aiv_video_timing_out #(
   parameter int CLKS_PER_PIXEL = 6,
   parameter int H_ACTIVE       = 640,
   parameter int H_FP           = 16,
   parameter int H_SYNC         = 64,
   parameter int H_BP           = 80,
   parameter int V_ACTIVE       = 576,
   parameter int V_FP           = 5,
   parameter int V_SYNC         = 5,
   parameter int V_BP           = 39
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] rgb_111_in,
   output logic [2:0] clk_phase,
   output logic       pixel_ce_out,
   output logic       frame_start_flag_out,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       de,
   output logic [2:0] rgb_111_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [2:0] PH_LAST  = 3'(CLKS_PER_PIXEL - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [2:0] phase_q, phase_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       de_q, de_d;
   logic       hsync_n_q, hsync_n_d;
   logic       vsync_n_q, vsync_n_d;
   logic [2:0] rgb_q, rgb_d;

   logic phase_wrap, h_wrap, v_wrap;
   logic active, hsync_win, vsync_win, capture;

   assign phase_wrap = (phase_q == PH_LAST);
   assign h_wrap     = (h_q == H_LAST);
   assign v_wrap     = (v_q == V_LAST);

   assign active    = (h_q < H_ACT) && (v_q < V_ACT);
   assign hsync_win = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
   assign vsync_win = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

   // Framebuffer data arrives the clock after the request, i.e. during phase 1.
   assign capture = enable && (phase_q == 3'd1);

   always_comb begin
      phase_d = phase_q;
      h_d     = h_q;
      v_d     = v_q;
      if (enable) begin
         phase_d = phase_wrap ? 3'd0 : phase_q + 3'd1;
         if (phase_wrap) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
               v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end
         end
      end
   end

   always_comb begin
      de_d      = de_q;
      hsync_n_d = hsync_n_q;
      vsync_n_d = vsync_n_q;
      rgb_d     = rgb_q;
      if (capture) begin
         de_d      = active;
         hsync_n_d = ~hsync_win;
         vsync_n_d = ~vsync_win;
         rgb_d     = active ? rgb_111_in : 3'b000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q   <= 3'd0;
         h_q       <= 10'd0;
         v_q       <= 10'd0;
         de_q      <= 1'b0;
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
         rgb_q     <= 3'b000;
      end else begin
         phase_q   <= phase_d;
         h_q       <= h_d;
         v_q       <= v_d;
         de_q      <= de_d;
         hsync_n_q <= hsync_n_d;
         vsync_n_q <= vsync_n_d;
         rgb_q     <= rgb_d;
      end
   end

   // Strobes are gated by reset so the reset state (phase 0 at 0,0) cannot request a pixel.
   assign pixel_ce_out         = ~reset && enable && (phase_q == 3'd0) && active;
   assign frame_start_flag_out = ~reset && enable && (phase_q == 3'd0) && h_wrap && v_wrap;

   assign clk_phase   = phase_q;
   assign h_count     = h_q;
   assign v_count     = v_q;
   assign de          = de_q;
   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign rgb_111_out = rgb_q;

endmodule

// File: tb/tb_aiv_video_timing_out.sv
// Bench: small-raster instance (directed table + slot-indexed reference model over 3+ frames)
// and a default-raster instance checked over its first line including an enable gap.
module tb_aiv_video_timing_out;

   localparam int S_CPP = 2;
   localparam int S_HA  = 4;
   localparam int S_VA  = 2;
   localparam int S_HT  = 7;
   localparam int S_VT  = 5;
   localparam int S_HSY = 5;
   localparam int S_VSY = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic       s_rst, s_en;
   logic [2:0] s_rgb_i, s_ph, s_rgb;
   logic       s_pce, s_fs, s_hs, s_vs, s_de;
   logic [9:0] s_h, s_v;

   logic       d_rst, d_en;
   logic [2:0] d_rgb_i, d_ph, d_rgb;
   logic       d_pce, d_fs, d_hs, d_vs, d_de;
   logic [9:0] d_h, d_v;

   aiv_video_timing_out #(
      .CLKS_PER_PIXEL(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_small (
      .clk(clk), .reset(s_rst), .enable(s_en), .rgb_111_in(s_rgb_i),
      .clk_phase(s_ph), .pixel_ce_out(s_pce), .frame_start_flag_out(s_fs),
      .h_count(s_h), .v_count(s_v), .hsync_n(s_hs), .vsync_n(s_vs),
      .de(s_de), .rgb_111_out(s_rgb)
   );

   aiv_video_timing_out u_dflt (
      .clk(clk), .reset(d_rst), .enable(d_en), .rgb_111_in(d_rgb_i),
      .clk_phase(d_ph), .pixel_ce_out(d_pce), .frame_start_flag_out(d_fs),
      .h_count(d_h), .v_count(d_v), .hsync_n(d_hs), .vsync_n(d_vs),
      .de(d_de), .rgb_111_out(d_rgb)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [2:0] rgb;
      logic [2:0] ph;
      logic [9:0] h;
      logic [9:0] v;
      logic       pce;
      logic       fs;
      logic       de;
      logic       hs;
      logic       vs;
      logic [2:0] ro;
   } vec_t;

   vec_t tv [22];

   function automatic vec_t mk(input logic rst, input logic en, input logic [2:0] rgb,
                               input logic [2:0] ph, input int h, input int v,
                               input logic pce, input logic fs, input logic de,
                               input logic hs, input logic vs, input logic [2:0] ro);
      vec_t t;
      t.rst = rst; t.en = en; t.rgb = rgb; t.ph = ph; t.h = 10'(h); t.v = 10'(v);
      t.pce = pce; t.fs = fs; t.de = de; t.hs = hs; t.vs = vs; t.ro = ro;
      return t;
   endfunction

   task automatic check_out(input string name, input logic [2:0] ph, input logic [9:0] h,
                            input logic [9:0] v, input logic pce, input logic fs,
                            input logic de, input logic hs, input logic vs,
                            input logic [2:0] ro);
      n_vec++;
      if ({s_ph, s_h, s_v, s_pce, s_fs, s_de, s_hs, s_vs, s_rgb} !==
          {ph, h, v, pce, fs, de, hs, vs, ro}) begin
         n_bad++;
         $display("FAIL %s: got ph=%0d h=%0d v=%0d pce=%b fs=%b de=%b hs=%b vs=%b rgb=%0d ; want ph=%0d h=%0d v=%0d pce=%b fs=%b de=%b hs=%b vs=%b rgb=%0d",
                  name, s_ph, s_h, s_v, s_pce, s_fs, s_de, s_hs, s_vs, s_rgb,
                  ph, h, v, pce, fs, de, hs, vs, ro);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, exp);
      end
   endtask

   // Reference model: linear slot index plus phase; outputs registered on phase 1.
   int         m_p, m_s;
   logic       m_de, m_hs, m_vs;
   logic [2:0] m_rgb;

   task automatic model_reset();
      m_p = 0; m_s = 0; m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_rgb = 3'b000;
   endtask

   task automatic model_check(input string name);
      int h, v;
      logic act, e_pce, e_fs;
      h = m_s % S_HT;
      v = m_s / S_HT;
      act   = (h < S_HA) && (v < S_VA);
      e_pce = !s_rst && s_en && (m_p == 0) && act;
      e_fs  = !s_rst && s_en && (m_p == 0) && (m_s == S_HT * S_VT - 1);
      check_out(name, 3'(m_p), 10'(h), 10'(v), e_pce, e_fs, m_de, m_hs, m_vs, m_rgb);
   endtask

   task automatic model_step();
      int h, v;
      logic act;
      if (s_rst) begin
         model_reset();
      end else if (s_en) begin
         h = m_s % S_HT;
         v = m_s / S_HT;
         act = (h < S_HA) && (v < S_VA);
         if (m_p == 1) begin
            m_de  = act;
            m_hs  = !(h == S_HSY);
            m_vs  = !(v == S_VSY);
            m_rgb = act ? s_rgb_i : 3'b000;
         end
         m_p++;
         if (m_p == S_CPP) begin
            m_p = 0;
            m_s = (m_s + 1) % (S_HT * S_VT);
         end
      end
   endtask

   initial begin
      int pce_cnt, fs_cnt, first_fs, last_fs, fs_gap_bad;
      int d_pce0, d_de0, d_hs0, first_hs_h, gap_bad, en_since, have_prev;
      int drop_left, dropped, drop_bad, resume_pending, d_fs_cnt, done;

      s_rst = 1'b1; s_en = 1'b0; s_rgb_i = 3'd0;
      d_rst = 1'b1; d_en = 1'b0; d_rgb_i = 3'd5;

      //        rst en rgb  ph h v  pce fs de hs vs ro
      tv[0]  = mk(1, 1, 5,  0, 0, 0, 0, 0, 0, 1, 1, 0);
      tv[1]  = mk(0, 1, 5,  0, 0, 0, 1, 0, 0, 1, 1, 0);
      tv[2]  = mk(0, 1, 5,  1, 0, 0, 0, 0, 0, 1, 1, 0);
      tv[3]  = mk(0, 1, 3,  0, 1, 0, 1, 0, 1, 1, 1, 5);
      tv[4]  = mk(0, 1, 3,  1, 1, 0, 0, 0, 1, 1, 1, 5);
      tv[5]  = mk(0, 0, 6,  0, 2, 0, 0, 0, 1, 1, 1, 3);
      tv[6]  = mk(0, 0, 6,  0, 2, 0, 0, 0, 1, 1, 1, 3);
      tv[7]  = mk(0, 1, 6,  0, 2, 0, 1, 0, 1, 1, 1, 3);
      tv[8]  = mk(0, 0, 6,  1, 2, 0, 0, 0, 1, 1, 1, 3);
      tv[9]  = mk(0, 1, 6,  1, 2, 0, 0, 0, 1, 1, 1, 3);
      tv[10] = mk(0, 1, 2,  0, 3, 0, 1, 0, 1, 1, 1, 6);
      tv[11] = mk(0, 1, 2,  1, 3, 0, 0, 0, 1, 1, 1, 6);
      tv[12] = mk(0, 1, 7,  0, 4, 0, 0, 0, 1, 1, 1, 2);
      tv[13] = mk(0, 1, 7,  1, 4, 0, 0, 0, 1, 1, 1, 2);
      tv[14] = mk(0, 1, 7,  0, 5, 0, 0, 0, 0, 1, 1, 0);
      tv[15] = mk(0, 1, 7,  1, 5, 0, 0, 0, 0, 1, 1, 0);
      tv[16] = mk(0, 1, 7,  0, 6, 0, 0, 0, 0, 0, 1, 0);
      tv[17] = mk(0, 1, 7,  1, 6, 0, 0, 0, 0, 0, 1, 0);
      tv[18] = mk(0, 1, 7,  0, 0, 1, 1, 0, 0, 1, 1, 0);
      tv[19] = mk(1, 1, 7,  1, 0, 1, 0, 0, 0, 1, 1, 0);
      tv[20] = mk(1, 1, 7,  0, 0, 0, 0, 0, 0, 1, 1, 0);
      tv[21] = mk(0, 1, 7,  0, 0, 0, 1, 0, 0, 1, 1, 0);

      @(posedge clk); #1;

      for (int i = 0; i < 22; i++) begin
         s_rst = tv[i].rst; s_en = tv[i].en; s_rgb_i = tv[i].rgb;
         #1;
         check_out($sformatf("vec%0d", i), tv[i].ph, tv[i].h, tv[i].v, tv[i].pce,
                   tv[i].fs, tv[i].de, tv[i].hs, tv[i].vs, tv[i].ro);
         @(posedge clk); #1;
      end

      // Small raster against the model: 3 full frames, then random enable gaps and a reset.
      s_rst = 1'b1; s_en = 1'b1;
      @(posedge clk); #1;
      model_reset();
      pce_cnt = 0; fs_cnt = 0; first_fs = -1; last_fs = -1; fs_gap_bad = 0;
      for (int c = 0; c < 310; c++) begin
         s_en    = (c < 210) ? 1'b1 : ($urandom_range(0, 3) != 0);
         s_rst   = (c == 250);
         s_rgb_i = 3'($urandom_range(0, 7));
         #1;
         model_check($sformatf("model_cyc%0d", c));
         if (c < 210) begin
            if (s_pce) pce_cnt++;
            if (s_fs) begin
               fs_cnt++;
               if (last_fs >= 0 && (c - last_fs) != S_HT * S_VT * S_CPP) fs_gap_bad++;
               if (first_fs < 0) first_fs = c;
               last_fs = c;
            end
         end
         model_step();
         @(posedge clk); #1;
      end
      check_int("small_pce_3frames", pce_cnt, 24);
      check_int("small_fs_3frames", fs_cnt, 3);
      check_int("small_first_fs_cycle", first_fs, 68);
      check_int("small_fs_gap_errors", fs_gap_bad, 0);

      // Default raster: first line plus an enable gap of 17 clocks at h=100, phase 3.
      d_pce0 = 0; d_de0 = 0; d_hs0 = 0; first_hs_h = -1; gap_bad = 0; en_since = 0;
      have_prev = 0; drop_left = 0; dropped = 0; drop_bad = 0; resume_pending = 0;
      d_fs_cnt = 0; done = 0;
      d_rst = 1'b1; d_en = 1'b1;
      @(posedge clk); #1;
      d_rst = 1'b0;
      for (int c = 0; c < 12000 && done == 0; c++) begin
         if (dropped == 0 && d_h == 10'd100 && d_ph == 3'd3) begin
            dropped = 1;
            drop_left = 17;
         end
         d_en = (drop_left == 0);
         d_rgb_i = 3'($urandom_range(0, 7));
         #1;
         if (resume_pending != 0) begin
            check_int("dflt_resume_phase", int'(d_ph), 3);
            check_int("dflt_resume_h", int'(d_h), 100);
            resume_pending = 0;
         end
         if (drop_left > 0) begin
            if (d_h != 10'd100 || d_ph != 3'd3 || d_pce || d_fs) drop_bad++;
            drop_left--;
            if (drop_left == 0) resume_pending = 1;
         end
         if (d_fs) d_fs_cnt++;
         if (d_pce) begin
            if (have_prev != 0 && d_h != 10'd0 && en_since != 6) gap_bad++;
            have_prev = 1;
            en_since = 0;
            if (d_v == 10'd0) d_pce0++;
         end
         if (d_ph == 3'd2 && d_v == 10'd0) begin
            if (d_de) d_de0++;
            if (!d_hs) begin
               d_hs0++;
               if (first_hs_h < 0) first_hs_h = int'(d_h);
            end
         end
         if (d_v == 10'd1 && d_h == 10'd20) done = 1;
         if (d_en) en_since++;
         @(posedge clk); #1;
      end
      if (done == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL dflt_run_timeout: got h=%0d v=%0d want v=1 h=20 within budget", d_h, d_v);
      end
      check_int("dflt_pce_line0", d_pce0, 640);
      check_int("dflt_de_slots_line0", d_de0, 640);
      check_int("dflt_hsync_slots_line0", d_hs0, 64);
      check_int("dflt_hsync_first_h", first_hs_h, 656);
      check_int("dflt_pce_spacing_errors", gap_bad, 0);
      check_int("dflt_enable_gap_errors", drop_bad, 0);
      check_int("dflt_fs_in_first_line", d_fs_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
